edge_pipe_bank: RTL and testbench
=================================

# edge_pipe_bank

Multi-channel, parametrised successor to the team's single-bit negative-edge D flip-flop. Each of CHANNELS lanes is a WIDTH-bit, DEPTH-stage register pipeline with a per-lane capture enable, a per-lane force/override path, complementary outputs and a fill-tracking valid flag. The block sits on register-file and test-override paths wherever a lane value must be pipelined but also pinned to a known value on demand.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (>=1)
- DEPTH, 2, pipeline stages per channel (>=1)
- CHANNELS, 4, independent lanes (>=1)
- NEG_EDGE, 1, 1 = active edge is falling clk; 0 = rising clk
- RESET_VAL, 0, WIDTH-bit value loaded into every stage on reset

Ports:
- clk  in  1  clock; active edge selected by NEG_EDGE
- reset  in  1  reset, synchronous, active-high
- d  in  CHANNELS*WIDTH  capture data; lane c at bits [c*WIDTH +: WIDTH]
- en  in  CHANNELS  per-lane capture/shift enable
- force_en  in  CHANNELS  per-lane override request
- force_val  in  CHANNELS*WIDTH  per-lane override value
- q  out  CHANNELS*WIDTH  lane output
- qbar  out  CHANNELS*WIDTH  bitwise inverse of q
- valid  out  CHANNELS  lane pipeline fully filled with captured data
- forced  out  CHANNELS  lane currently overridden (equals force_en)

## Operation
- Per lane: stage registers s[0..DEPTH-1], fill counter cnt (0..DEPTH, saturating), all updated only on the active edge.
- Update priority per lane at each active edge: reset > force_en[c] > en[c] > hold.
- reset: all s[k] <= RESET_VAL, cnt <= 0, all lanes.
- force_en[c]: all s[k] of lane c <= force_val[c]; cnt[c] <= 0. en[c] ignored.
- en[c] (no reset, no force): s[0] <= d[c]; s[k] <= s[k-1]; cnt <= min(cnt+1, DEPTH).
- Otherwise: lane holds; cnt holds.
- Output mux (combinational): q[c] = force_val[c] when force_en[c]=1, else s[DEPTH-1]. Override takes effect immediately, not at the next edge, and applies during reset as well.
- qbar = ~q at all times, including under override.
- valid[c] = (cnt[c] == DEPTH) and force_en[c]=0.
- Release (force_en[c] falls): q[c] shows s[DEPTH-1], which holds the last force_val loaded; regular capture resumes on the next enabled edge. If force_en fell before any active edge while forced, q reverts to the pre-force stage value.
- Lanes are fully independent; no cross-lane interaction.

## Timing
- Reset state (after first active edge with reset=1): q = RESET_VAL per lane (unless forced), qbar = ~RESET_VAL, valid = 0, forced = force_en.
- Latency: d[c] captured with en[c]=1 at active edge N appears on q[c] after enabled edge N+DEPTH-1 (DEPTH enabled edges total; gaps in en stretch latency).
- DEPTH=1: single register per lane; q updates at the capturing edge.
- valid[c] rises after the DEPTH-th enabled edge following reset or force release; stays high while en toggles; cnt never wraps.
- Simultaneous reset and force_en: reset wins on state; q still shows force_val combinationally.
- Simultaneous force_en and en: force wins; d discarded.
- Reset mid-fill: cnt returns to 0; valid low until DEPTH new enabled edges.
- Only the selected edge updates state; the opposite edge never changes any register.

## Test plan
- Reset: WIDTH=8, DEPTH=2, RESET_VAL=8'h5A; assert reset one active edge -> all q=8'h5A, qbar=8'hA5, valid=0.
- Latency/fill: lane0 en=1, d=8'h11 then 8'h22 on consecutive falling edges -> q0=8'h11 after 2nd edge, valid0=1 after 2nd edge, q0=8'h22 after 3rd; rising edges change nothing.
- Override: q1=8'h33 with valid1=1; force_en1=1, force_val1=8'hF0 -> q1=8'hF0 and forced1=1 same cycle, valid1=0; release after one edge -> q1 stays 8'hF0 until next en edge, valid1 returns after DEPTH enabled edges.
- Priority: reset=1, force_en2=1, en2=1 same edge -> lane2 stages = RESET_VAL, q2=force_val2; drop force -> q2=RESET_VAL.
- Lane independence / hold: en toggles only on lane3, en=0 elsewhere -> other lanes' q, valid unchanged for 10 edges.
- Edge mode: NEG_EDGE=0, DEPTH=1 -> d captured on rising edge, q updates at that edge, falling edges ignored.

Source files
------------

// File: rtl/edge_pipe_bank.sv
// edge_pipe_bank: CHANNELS independent WIDTH-bit, DEPTH-stage register
// pipelines. Each lane has a capture enable, a force/override path that
// loads every stage and also drives the output immediately, complementary
// outputs, and a flag that is high once the lane is filled with captured data.
// The active clock edge is chosen at elaboration time by NEG_EDGE.
module edge_pipe_bank #(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          DEPTH     = 2,
  parameter int unsigned          CHANNELS  = 4,
  parameter int unsigned          NEG_EDGE  = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       force_en,
  input  logic [CHANNELS*WIDTH-1:0] force_val,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] qbar,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       forced
);

  // Fill counter counts 0..DEPTH inclusive and saturates at DEPTH.
  localparam int unsigned        CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);

  // Stage k of lane c is stage_q[c][k]; stage DEPTH-1 feeds the output.
  logic [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CHANNELS-1:0][CNT_W-1:0]            cnt_q, cnt_d;

  // Next-state per lane with priority reset > force > enable > hold.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned; otherwise a latch is inferred.
    stage_d = stage_q;
    cnt_d   = cnt_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset) begin
        // NOTE: the pipeline stages are reset too, not just the counter,
        // so q shows a defined RESET_VAL straight after reset.
        for (int k = 0; k < DEPTH; k++) stage_d[c][k] = RESET_VAL;
        cnt_d[c] = '0;
      end else if (force_en[c]) begin
        for (int k = 0; k < DEPTH; k++) stage_d[c][k] = force_val[c*WIDTH +: WIDTH];
        cnt_d[c] = '0;
      end else if (en[c]) begin
        stage_d[c][0] = d[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) stage_d[c][k] = stage_q[c][k-1];
        if (cnt_q[c] != CNT_FULL) cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  // State registers clocked on the selected edge only; reset is folded into
  // the next-state logic above, so it is synchronous to that edge.
  if (NEG_EDGE != 0) begin : g_neg
    // Falling-edge state update.
    always_ff @(negedge clk) begin
      // NOTE: non-blocking assignments so all stages sample the old values
      // of their neighbours on the same edge.
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end else begin : g_pos
    // Rising-edge state update.
    always_ff @(posedge clk) begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mux: override is combinational and also applies during reset.
  always_comb begin
    q     = '0;
    valid = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      q[c*WIDTH +: WIDTH] = force_en[c] ? force_val[c*WIDTH +: WIDTH]
                                        : stage_q[c][DEPTH-1];
      valid[c] = (cnt_q[c] == CNT_FULL) && !force_en[c];
    end
  end

  assign qbar   = ~q;
  assign forced = force_en;

endmodule

// File: tb/tb_edge_pipe_bank.sv
// Directed bench for edge_pipe_bank: a falling-edge DEPTH=2 bank with
// RESET_VAL 8'h5A, and a rising-edge DEPTH=1 bank with two lanes.
module tb_edge_pipe_bank;

  logic clk;

  // Falling-edge instance.
  logic        reset;
  logic [31:0] d, force_val, q, qbar;
  logic [3:0]  en, force_en, valid, forced;

  // Rising-edge instance.
  logic        r_reset;
  logic [15:0] r_d, r_force_val, r_q, r_qbar;
  logic [1:0]  r_en, r_force_en, r_valid, r_forced;

  int n_checks = 0;
  int n_fail   = 0;

  edge_pipe_bank #(
    .WIDTH(8), .DEPTH(2), .CHANNELS(4), .NEG_EDGE(1), .RESET_VAL(8'h5A)
  ) dut (
    .clk(clk), .reset(reset), .d(d), .en(en), .force_en(force_en),
    .force_val(force_val), .q(q), .qbar(qbar), .valid(valid), .forced(forced)
  );

  edge_pipe_bank #(
    .WIDTH(8), .DEPTH(1), .CHANNELS(2), .NEG_EDGE(0), .RESET_VAL(8'h00)
  ) dut_r (
    .clk(clk), .reset(r_reset), .d(r_d), .en(r_en), .force_en(r_force_en),
    .force_val(r_force_val), .q(r_q), .qbar(r_qbar), .valid(r_valid),
    .forced(r_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fall_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic rise_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; d = '0; en = '0; force_en = '0; force_val = '0;
    r_reset = 1'b1; r_d = '0; r_en = '0; r_force_en = '0; r_force_val = '0;

    // Reset state
    fall_edge();
    reset = 1'b0;
    check("rst_q",      q,      32'h5A5A5A5A);
    check("rst_qbar",   qbar,   32'hA5A5A5A5);
    check("rst_valid",  valid,  4'h0);
    check("rst_forced", forced, 4'h0);

    // Latency and fill on lane 0
    en = 4'b0001; d[7:0] = 8'h11;
    fall_edge();
    check("lat1_q0",  q[7:0],   8'h5A);
    check("lat1_v0",  valid[0], 1'b0);
    d[7:0] = 8'h22;
    fall_edge();
    check("lat2_q0",  q[7:0],   8'h11);
    check("lat2_v0",  valid[0], 1'b1);
    d[7:0] = 8'h99;
    rise_edge();
    check("rise_q0",  q[7:0],   8'h11);
    fall_edge();
    check("lat3_q0",  q[7:0],   8'h22);
    check("lat3_v0",  valid,    4'b0001);
    en = '0;

    // Override on lane 1
    en = 4'b0010; d[15:8] = 8'h33;
    fall_edge();
    fall_edge();
    en = '0;
    check("pre_q1",   q[15:8],  8'h33);
    check("pre_v1",   valid[1], 1'b1);
    force_en = 4'b0010; force_val[15:8] = 8'hF0;
    #1;
    check("frc_q1",    q[15:8],    8'hF0);
    check("frc_qbar1", qbar[15:8], 8'h0F);
    check("frc_f",     forced,     4'b0010);
    check("frc_v",     valid,      4'b0001);
    fall_edge();
    force_en = '0;
    #1;
    check("rel_q1",   q[15:8],  8'hF0);
    check("rel_v1",   valid[1], 1'b0);
    en = 4'b0010; d[15:8] = 8'h44;
    fall_edge();
    check("rel1_q1",  q[15:8],  8'hF0);
    check("rel1_v1",  valid[1], 1'b0);
    d[15:8] = 8'h55;
    fall_edge();
    check("rel2_q1",  q[15:8],  8'h44);
    check("rel2_v1",  valid[1], 1'b1);
    en = '0;

    // Force raised and dropped between edges reverts to stage value
    force_en = 4'b0010; force_val[15:8] = 8'h77;
    #1;
    check("blip_q1",  q[15:8],  8'h77);
    force_en = '0;
    #1;
    check("unblip_q1", q[15:8], 8'h44);
    check("unblip_v1", valid[1], 1'b1);

    // Force beats enable; d discarded
    force_en = 4'b0010; en = 4'b0010; force_val[15:8] = 8'hC3; d[15:8] = 8'hAB;
    fall_edge();
    force_en = '0; en = '0;
    #1;
    check("fvse_q1",  q[15:8],  8'hC3);
    check("fvse_v1",  valid[1], 1'b0);

    // Reset beats force on state; output still shows force_val
    reset = 1'b1; force_en = 4'b0100; en = 4'b0100;
    force_val[23:16] = 8'hE7; d[23:16] = 8'h12;
    fall_edge();
    check("pri_q",    q,      32'h5AE75A5A);
    check("pri_v",    valid,  4'h0);
    check("pri_f",    forced, 4'b0100);
    reset = 1'b0; force_en = '0; en = '0;
    #1;
    check("pri_rel_q", q,     32'h5A5A5A5A);

    // Reset mid-fill on lane 2
    en = 4'b0100; d[23:16] = 8'h21;
    fall_edge();
    check("mid1_v2",  valid[2], 1'b0);
    reset = 1'b1;
    fall_edge();
    reset = 1'b0; d[23:16] = 8'h31;
    fall_edge();
    check("mid2_v2",  valid[2], 1'b0);
    check("mid2_q2",  q[23:16], 8'h5A);
    d[23:16] = 8'h32;
    fall_edge();
    check("mid3_v2",  valid[2], 1'b1);
    check("mid3_q2",  q[23:16], 8'h31);

    // Refill lane 0
    en = 4'b0001; d[7:0] = 8'h61;
    fall_edge();
    d[7:0] = 8'h62;
    fall_edge();
    check("fill_q",   q[23:0],  24'h315A61);
    check("fill_v",   valid,    4'b0101);

    // Lane independence: only lane 3 toggles its enable
    for (int i = 0; i < 10; i++) begin
      en = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      d  = {8'(8'h30 + i), 24'hEEEEEE};
      fall_edge();
      check("ind_q",  q[23:0],    24'h315A61);
      check("ind_v",  valid[2:0], 3'b101);
    end
    en = '0;
    check("ind_q3",   q,      32'h36315A61);
    check("ind_v3",   valid,  4'b1101);

    // Rising-edge, DEPTH=1 instance
    @(negedge clk);
    #1;
    rise_edge();
    r_reset = 1'b0;
    check("r_rst_q",    r_q,     16'h0000);
    check("r_rst_qbar", r_qbar,  16'hFFFF);
    check("r_rst_v",    r_valid, 2'b00);
    r_en = 2'b01; r_d = 16'h00A1;
    rise_edge();
    check("r_cap_q",  r_q,     16'h00A1);
    check("r_cap_v",  r_valid, 2'b01);
    r_d = 16'h00B2;
    fall_edge();
    check("r_fall_q", r_q,     16'h00A1);
    rise_edge();
    check("r_cap2_q", r_q,     16'h00B2);
    r_force_en = 2'b10; r_force_val = 16'h3C00;
    #1;
    check("r_frc_q",  r_q,      16'h3CB2);
    check("r_frc_f",  r_forced, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
